fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage that sits directly upstream of the decoder.
//  - Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
//  - Buffers returned words with their PCs in a small circular prefetch queue.
//  - Presents the queue head to the decoder with a valid/ready handshake.
//  - A branch from execute flushes the queue and redirects the PC.
// PARAMETERS
//  RESET_PC  32'h00000000  fetch address after reset (bits [1:0] must be 0)
//  QDEPTH    2             prefetch queue entries; power of two, >= 2
// PORTS
//  clk1           in   1   single system clock; all state updates on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  mem_req        out  1   read request to instruction memory
//  mem_addr       out  32  word-aligned read address, valid while mem_req=1
//  mem_ack        in   1   read complete; mem_rdata valid this cycle
//  mem_rdata      in   32  instruction word returned by memory
//  branch_valid   in   1   redirect request from execute (one-cycle pulse)
//  branch_target  in   32  new fetch address; bits [1:0] ignored, treated as 0
//  instr_valid    out  1   queue head is valid
//  instruction    out  32  queue head instruction word
//  instr_pc       out  32  address the queue head was fetched from
//  instr_ready    in   1   decoder accepts head this cycle
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0.
//   - pc=RESET_PC, queue empty, FSM=IDLE.
//  FSM states and transitions
//   - IDLE: if (count + 0) < QDEPTH and no branch, assert mem_req with mem_addr=pc; go to WAIT.
//   - WAIT: mem_req=1 and mem_addr held stable.
//     - mem_ack & !branch: push {mem_rdata, mem_addr}; pc += 4.
//       Re-issue next request back-to-back (stay WAIT, mem_addr=pc+4) if (count after push/pop) < QDEPTH, else go to IDLE.
//     - branch & !mem_ack: go to DROP (the request is still in flight).
//     - branch & mem_ack: discard the data; go to IDLE.
//   - DROP: mem_req=0. On mem_ack, discard the data and go to IDLE.
//     A further branch in DROP only updates pc.
//  Request path
//   - At most one request outstanding; the ack is sampled at posedge while req=1.
//   - Ack in the same cycle as req is legal.
//  Queue
//   - Circular buffer of QDEPTH entries; rd_ptr/wr_ptr wrap modulo QDEPTH; count 0..QDEPTH.
//   - instr_valid = (count != 0); pop on instr_valid & instr_ready.
//   - Simultaneous push and pop: count unchanged, both pointers advance.
//   - A push never occurs when count == QDEPTH; requests are issued only with room reserved.
//   - instruction/instr_pc are driven from the head entry (registered storage).
//  Branch
//   - branch_valid at posedge:
//     - Queue cleared (count=0, pointers reset) and pc = {branch_target[31:2], 2'b00}.
//     - instr_valid is 0 the next cycle.
//   - Branch overrides any pop or push in the same cycle.
//   - Latency: first request to the target issues the cycle after the branch (from IDLE), or after the DROP ack.
//  Arithmetic
//   - pc increments by 4 modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000.
//  Latency
//   - With ack in the request cycle, a fetched word appears on instr_valid the next cycle.
//   - Sustained throughput is 1 word/cycle when the decoder is always ready.
//  Reset mid-operation
//   - All state returns to reset values immediately.
//   - An in-flight ack arriving after reset release is ignored (FSM is IDLE, req=0 at that point).
// TESTING
//  1. Reset, mem_ack tied 1, instr_ready=1 -> instr_pc sequence 0,4,8,C; instruction equals memory words; one per cycle.
//  2. instr_ready=0, ack always 1 -> exactly QDEPTH(2) words queued; mem_req drops to 0.
//     Then raise ready -> words drain in order (pc 0 then 4) and fetch resumes at 8.
//  3. Ack delayed 3 cycles -> mem_req/mem_addr=0 held stable for 3 cycles; a single push with pc 0.
//  4. branch_valid with target 32'h0000_0103 while a request is pending -> late ack data discarded (DROP).
//     Next mem_addr=32'h100; queue empty the following cycle.
//  5. branch_valid coincident with mem_ack and a pop -> nothing queued.
//     Next fetch at target; instr_valid=0 the next cycle.
//  6. RESET_PC=32'hFFFFFFF8, ack 1 -> mem_addr FFFFFFF8, FFFFFFFC, 00000000 (wrap).
//     Assert rst_n=0 mid-wait -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to
// instruction memory over a req/ack handshake, buffers returned words with
// their PCs in a small circular prefetch queue, and presents the queue head
// to the decoder over valid/ready.  A branch flushes the queue and
// redirects the PC; a request already in flight at that moment is drained
// through the DROP state so its late data never reaches the queue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pc_seq_s;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;

  logic [31:0]       qinstr_q [QDEPTH];
  logic [31:0]       qinstr_d [QDEPTH];
  logic [31:0]       qpc_q    [QDEPTH];
  logic [31:0]       qpc_d    [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       instruction_q, instruction_d;
  logic [31:0]       instr_pc_q, instr_pc_d;

  logic              push_s;
  logic              pop_s;

  // A branch wins over both queue operations in the same cycle.
  assign push_s = (state_q == ST_WAIT) && mem_ack && !branch_valid;
  assign pop_s  = instr_valid_q && instr_ready && !branch_valid;

  // Prefetch queue update: flush on branch, otherwise push returned word and/or pop head.
  always_comb begin
    qinstr_d = qinstr_q;
    qpc_d    = qpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (branch_valid) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        qinstr_d[wr_ptr_q] = mem_rdata;
        qpc_d[wr_ptr_q]    = mem_addr_q;
        wr_ptr_d           = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Request FSM: issue only with a queue slot reserved, keep back-to-back
  // requests while room remains, and drain an in-flight request after a branch.
  always_comb begin
    state_d    = state_q;
    pc_seq_s   = pc_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (!branch_valid && (count_q < DEPTH_C)) begin
          state_d    = ST_WAIT;
          mem_addr_d = pc_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (branch_valid) begin
          if (mem_ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end else if (mem_ack) begin
          pc_seq_s = pc_q + 32'd4;
          if (count_d < DEPTH_C) begin
            state_d    = ST_WAIT;
            mem_addr_d = pc_q + 32'd4;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (branch_valid) begin
      pc_d = branch_target & 32'hFFFF_FFFC;
    end else begin
      pc_d = pc_seq_s;
    end
    mem_req_d = (state_d == ST_WAIT);
  end

  // Decoder-facing outputs are registered copies of the next queue head.
  always_comb begin
    instr_valid_d = (count_d != {CNT_W{1'b0}});
    instruction_d = qinstr_d[rd_ptr_d];
    instr_pc_d    = qpc_d[rd_ptr_d];
  end

  // State, queue storage and output registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_PC;
      rd_ptr_q      <= {PTR_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      instr_valid_q <= 1'b0;
      instruction_q <= 32'h0000_0000;
      instr_pc_q    <= 32'h0000_0000;
      for (int i = 0; i < QDEPTH; i++) begin
        qinstr_q[i] <= 32'h0000_0000;
        qpc_q[i]    <= 32'h0000_0000;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      instr_valid_q <= instr_valid_d;
      instruction_q <= instruction_d;
      instr_pc_q    <= instr_pc_d;
      for (int i = 0; i < QDEPTH; i++) begin
        qinstr_q[i] <= qinstr_d[i];
        qpc_q[i]    <= qpc_d[i];
      end
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instruction = instruction_q;
  assign instr_pc    = instr_pc_q;

endmodule
